// File: rtl/ook_pkg.sv
// Shared encodings and default timing constants for the OOK beacon receiver.
package ook_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMark,
    StSpace
  } state_e;

  localparam int unsigned DefUnitCycles      = 2097152;
  localparam int unsigned DefDashMinUnits    = 2;
  localparam int unsigned DefLetterGapUnits  = 2;
  localparam int unsigned DefWordGapUnits    = 5;
  localparam int unsigned DefMaxSyms         = 8;
  localparam int unsigned UnitMax            = 15;

  localparam logic SymDot  = 1'b0;
  localparam logic SymDash = 1'b1;

endpackage

// File: rtl/ook_pattern_rx_if.sv
// Pin-side input and decoded character stream of the OOK receiver.
interface ook_pattern_rx_if
  import ook_pkg::*;
#(
  parameter int unsigned MAX_SYMS = DefMaxSyms
);
  logic                rx_in;
  logic                line_active;
  logic                char_valid;
  logic [MAX_SYMS-1:0] char_bits;
  logic [3:0]          char_len;
  logic                char_ovf;
  logic                word_end;

  modport master (
    input  rx_in,
    output line_active, char_valid, char_bits, char_len, char_ovf, word_end
  );

  modport slave (
    output rx_in,
    input  line_active, char_valid, char_bits, char_len, char_ovf, word_end
  );
endinterface

// File: rtl/ook_unit_timer.sv
// Prescaler plus saturating 4-bit unit counter; both clear on i_clr.
module ook_unit_timer
  import ook_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = DefUnitCycles
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_clr,
  output logic [3:0] o_units,
  output logic       o_wrap
);
  localparam int unsigned PrescW = $clog2(UNIT_CYCLES);

  logic [PrescW-1:0] r_presc;
  logic [3:0]        r_units;

  // Wrap is reported even on a clear cycle so coincident events are not lost.
  assign o_wrap  = (r_presc == PrescW'(UNIT_CYCLES - 1));
  assign o_units = r_units;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc <= '0;
      r_units <= '0;
    end else if (i_clr) begin
      r_presc <= '0;
      r_units <= '0;
    end else if (o_wrap) begin
      r_presc <= '0;
      if (r_units != 4'(UnitMax)) r_units <= r_units + 4'd1;
    end else begin
      r_presc <= r_presc + PrescW'(1);
    end
  end
endmodule

// File: rtl/ook_pattern_rx.sv
// OOK/Morse beacon receiver: times marks and spaces, assembles dot/dash characters.
module ook_pattern_rx
  import ook_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES      = DefUnitCycles,
  parameter int unsigned DASH_MIN_UNITS   = DefDashMinUnits,
  parameter int unsigned LETTER_GAP_UNITS = DefLetterGapUnits,
  parameter int unsigned WORD_GAP_UNITS   = DefWordGapUnits,
  parameter int unsigned MAX_SYMS         = DefMaxSyms
) (
  input  logic            CLK,
  input  logic            RST,
  ook_pattern_rx_if.master bus
);
  logic r_sync1, r_line, r_line_d;
  logic w_rise, w_fall;
  logic [3:0] w_units, w_eff_units;
  logic w_wrap, w_letter, w_word;

  state_e              r_state;
  logic [MAX_SYMS-1:0] r_bits;
  logic [3:0]          r_len;
  logic                r_ovf, r_append, r_dash, r_char_seen;
  logic                r_char_valid, r_char_ovf, r_word_end;
  logic [MAX_SYMS-1:0] r_char_bits;
  logic [3:0]          r_char_len;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1  <= 1'b0;
      r_line   <= 1'b0;
      r_line_d <= 1'b0;
    end else begin
      r_sync1  <= bus.rx_in;
      r_line   <= r_sync1;
      r_line_d <= r_line;
    end
  end

  assign w_rise = r_line & ~r_line_d;
  assign w_fall = ~r_line & r_line_d;

  ook_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .i_clr  (w_rise | w_fall),
    .o_units(w_units),
    .o_wrap (w_wrap)
  );

  // Count including a wrap landing this cycle, so N units read as N on the edge itself.
  assign w_eff_units = (w_units == 4'(UnitMax)) ? w_units : w_units + {3'b000, w_wrap};
  assign w_letter    = w_wrap && (w_units == 4'(LETTER_GAP_UNITS - 1));
  assign w_word      = w_wrap && (w_units == 4'(WORD_GAP_UNITS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= StIdle;
      r_bits       <= '0;
      r_len        <= '0;
      r_ovf        <= 1'b0;
      r_append     <= 1'b0;
      r_dash       <= SymDot;
      r_char_seen  <= 1'b0;
      r_char_valid <= 1'b0;
      r_char_bits  <= '0;
      r_char_len   <= '0;
      r_char_ovf   <= 1'b0;
      r_word_end   <= 1'b0;
    end else begin
      r_char_valid <= 1'b0;
      r_word_end   <= 1'b0;
      r_append     <= 1'b0;

      if (r_append) begin
        if (r_len < 4'(MAX_SYMS)) begin
          r_bits <= {r_bits[MAX_SYMS-2:0], r_dash};
          r_len  <= r_len + 4'd1;
        end else begin
          r_ovf <= 1'b1;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (w_rise) r_state <= StMark;
        end
        StMark: begin
          if (w_fall) begin
            r_state  <= StSpace;
            r_append <= 1'b1;
            r_dash   <= (w_eff_units >= 4'(DASH_MIN_UNITS)) ? SymDash : SymDot;
          end
        end
        StSpace: begin
          if (w_letter && (r_len != 4'd0)) begin
            r_char_valid <= 1'b1;
            r_char_bits  <= r_bits;
            r_char_len   <= r_len;
            r_char_ovf   <= r_ovf;
            r_bits       <= '0;
            r_len        <= '0;
            r_ovf        <= 1'b0;
            r_char_seen  <= 1'b1;
          end
          if (w_word) begin
            if (r_char_seen) begin
              r_word_end  <= 1'b1;
              r_char_seen <= 1'b0;
            end
            r_state <= StIdle;
          end
          // A rise always starts a new mark, even on a gap-boundary cycle.
          if (w_rise) r_state <= StMark;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.line_active = r_line;
  assign bus.char_valid  = r_char_valid;
  assign bus.char_bits   = r_char_bits;
  assign bus.char_len    = r_char_len;
  assign bus.char_ovf    = r_char_ovf;
  assign bus.word_end    = r_word_end;
endmodule

// File: tb/tb_ook_pattern_rx.sv
// Scoreboard bench for ook_pattern_rx with a 4-cycle time unit.
module tb_ook_pattern_rx;
  localparam int unsigned U = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ook_pattern_rx_if #(.MAX_SYMS(8)) bus ();

  ook_pattern_rx #(
    .UNIT_CYCLES     (U),
    .DASH_MIN_UNITS  (2),
    .LETTER_GAP_UNITS(2),
    .WORD_GAP_UNITS  (5),
    .MAX_SYMS        (8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       word;
    logic [7:0] bits;
    logic [3:0] len;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests   = 0;
  int   n_fail    = 0;
  bit   chk_reset = 1'b0;
  bit   chk_end   = 1'b0;

  task automatic push_char(input logic [7:0] b, input logic [3:0] l, input logic o);
    exp_t x;
    x.word = 1'b0; x.bits = b; x.len = l; x.ovf = o;
    exp_q.push_back(x);
  endtask

  task automatic push_word();
    exp_t x;
    x.word = 1'b1; x.bits = '0; x.len = '0; x.ovf = 1'b0;
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic v, input int n);
    bus.rx_in = v;
    repeat (n * U) @(negedge clk);
  endtask

  // Symbols sent MSB first; dash = 3u mark, dot = 1u mark, 1u intra-char space.
  task automatic send_char(input logic [15:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b1, pat[i] ? 3 : 1);
      if (i > 0) drive(1'b0, 1);
    end
  endtask

  // Monitor: owns all counters; pops the scoreboard on every strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_reset) begin
        n_tests++;
        if ({bus.line_active, bus.char_valid, bus.char_bits, bus.char_len, bus.char_ovf,
             bus.word_end} != '0) begin
          n_fail++;
          $display("FAIL reset_outputs: got la=%0b cv=%0b bits=%b len=%0d ovf=%0b we=%0b, want all 0",
                   bus.line_active, bus.char_valid, bus.char_bits, bus.char_len, bus.char_ovf,
                   bus.word_end);
        end
      end else if (bus.char_valid || bus.word_end) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got cv=%0b we=%0b bits=%b len=%0d ovf=%0b, want none",
                   bus.char_valid, bus.word_end, bus.char_bits, bus.char_len, bus.char_ovf);
        end else begin
          e = exp_q.pop_front();
          if (e.word) begin
            if (!(bus.word_end && !bus.char_valid)) begin
              n_fail++;
              $display("FAIL word_end: got cv=%0b we=%0b bits=%b len=%0d, want word_end only",
                       bus.char_valid, bus.word_end, bus.char_bits, bus.char_len);
            end
          end else if (!(bus.char_valid && !bus.word_end && bus.char_bits == e.bits &&
                         bus.char_len == e.len && bus.char_ovf == e.ovf)) begin
            n_fail++;
            $display("FAIL char: got cv=%0b we=%0b bits=%b len=%0d ovf=%0b, want bits=%b len=%0d ovf=%0b",
                     bus.char_valid, bus.word_end, bus.char_bits, bus.char_len, bus.char_ovf,
                     e.bits, e.len, e.ovf);
          end
        end
      end
      if (chk_end) begin
        n_tests++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL missing_events: got %0d expected events never seen, want 0",
                   exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] pat;
    bus.rx_in = 1'b0;
    rst       = 1'b1;
    chk_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.rx_in = ~bus.rx_in;
    end
    bus.rx_in = 1'b0;
    @(negedge clk);
    chk_reset = 1'b0;
    rst       = 1'b0;
    repeat (100) @(negedge clk);

    // S
    push_char(8'b000, 4'd3, 1'b0); push_word();
    send_char(16'b000, 3); drive(1'b0, 20);

    // O
    push_char(8'b111, 4'd3, 1'b0); push_word();
    send_char(16'b111, 3); drive(1'b0, 20);

    // K then A in one word
    push_char(8'b101, 4'd3, 1'b0); push_char(8'b01, 4'd2, 1'b0); push_word();
    send_char(16'b101, 3); drive(1'b0, 3); send_char(16'b01, 2); drive(1'b0, 20);

    // Saturating 20u mark is a dash
    push_char(8'b1, 4'd1, 1'b0); push_word();
    drive(1'b1, 20); drive(1'b0, 20);

    // Beacon stream twice; word gap coincides with the next rise on the repeat
    pat = 32'b101010001110111011100010101;
    repeat (2) begin
      push_char(8'b000, 4'd3, 1'b0); push_char(8'b111, 4'd3, 1'b0);
      push_char(8'b000, 4'd3, 1'b0); push_word();
      for (int i = 0; i < 32; i++) drive(pat[i], 1);
    end
    drive(1'b0, 20);

    // Overflow: ten dots, then a normal S
    push_char(8'b0, 4'd8, 1'b1); push_char(8'b000, 4'd3, 1'b0); push_word();
    send_char(16'b0, 10); drive(1'b0, 3); send_char(16'b000, 3); drive(1'b0, 20);

    // Reset during the second mark of O discards everything
    drive(1'b1, 3); drive(1'b0, 1); drive(1'b1, 2);
    rst       = 1'b1;
    chk_reset = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset = 1'b0;
    rst       = 1'b0;
    drive(1'b0, 20);

    chk_end = 1'b1;
  end
endmodule
